mux_select_sequencer: RTL and testbench

Frame-level sequencer that sits directly upstream of the 8:1 single-bit multiplexer. It accepts an 8-bit word and an 8-bit channel-enable mask over a valid/ready handshake, holds the word on the mux data bus, and steps the mux select line through the enabled channels in order. The selected mux output comes back into this block and is forwarded as a serial bit stream with its own valid/ready handshake. Optional idle gap cycles follow each frame.

---
 rtl/mux_select_sequencer.sv | 126 ++++++++++++
 tb/tb_mux_select_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// Frame sequencer feeding an external 8:1 single-bit mux: latches a word plus a channel mask,
// walks mux_sel through the enabled channels and forwards the mux output as a serial stream.
module mux_select_sequencer #(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_mask,
  output logic [7:0] mux_data,
  output logic [2:0] mux_sel,
  input  logic       mux_bit,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_bit,
  output logic [2:0] ser_chan,
  output logic       ser_last,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [3:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam state_t     AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t     state, stateNext;
  logic [7:0] chanMask, chanMaskNext;
  logic [7:0] muxDataNext;
  logic [2:0] muxSelNext;
  logic [3:0] gapCnt, gapCntNext;
  logic       frameDoneNext;
  logic       firstFound, nextFound;
  logic [2:0] firstChan, nextChan;

  // Priority search in scan order; walking positions backwards lets the earliest hit win.
  // With fromStart clear, only channels strictly beyond cur (no wrap-around) qualify.
  function automatic logic [3:0] scanSearch(input logic [7:0] mask, input logic [2:0] cur,
                                            input logic fromStart);
    logic [3:0] result;
    logic [2:0] chIdx;
    int         ch;
    logic       beyond;
    result = 4'b0;
    for (int s = 7; s >= 0; s--) begin
      ch     = MSB_FIRST ? (7 - s) : s;
      chIdx  = ch[2:0];
      beyond = MSB_FIRST ? (ch < int'(cur)) : (ch > int'(cur));
      if (mask[chIdx] && (fromStart || beyond)) result = {1'b1, chIdx};
    end
    return result;
  endfunction

  assign {firstFound, firstChan} = scanSearch(in_mask, 3'd0, 1'b1);
  assign {nextFound, nextChan}   = scanSearch(chanMask, mux_sel, 1'b0);

  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_bit   = mux_bit;
  assign ser_chan  = mux_sel;
  assign ser_last  = ser_valid && !nextFound;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    stateNext     = state;
    muxDataNext   = mux_data;
    chanMaskNext  = chanMask;
    muxSelNext    = mux_sel;
    gapCntNext    = gapCnt;
    frameDoneNext = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          muxDataNext  = in_data;
          chanMaskNext = in_mask;
          if (firstFound) begin
            muxSelNext = firstChan;
            stateNext  = SHIFT;
          end else begin
            frameDoneNext = 1'b1;
            gapCntNext    = GAP_LOAD;
            stateNext     = AFTER_FRAME;
          end
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (nextFound) begin
            muxSelNext = nextChan;
          end else begin
            frameDoneNext = 1'b1;
            gapCntNext    = GAP_LOAD;
            stateNext     = AFTER_FRAME;
          end
        end
      end
      GAP: begin
        if (gapCnt == 4'd0) stateNext = IDLE;
        else                gapCntNext = gapCnt - 4'd1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mux_data   <= '0;
      mux_sel    <= '0;
      chanMask   <= '0;
      gapCnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= stateNext;
      mux_data   <= muxDataNext;
      mux_sel    <= muxSelNext;
      chanMask   <= chanMaskNext;
      gapCnt     <= gapCntNext;
      frame_done <= frameDoneNext;
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench: dut0 uses default parameters, dut1 scans MSB first with a 3-cycle gap.
// Each DUT drives a behavioural 8:1 mux; serial output is matched against a scoreboard queue.
module tb_mux_select_sequencer;

  typedef struct packed {
    logic [2:0] chan;
    logic       bitv;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid0, in_ready0, mux_bit0, ser_valid0, ser_ready0, ser_bit0, ser_last0, frame_done0;
  logic [7:0] in_data0, in_mask0, mux_data0;
  logic [2:0] mux_sel0, ser_chan0;
  logic       in_valid1, in_ready1, mux_bit1, ser_valid1, ser_ready1, ser_bit1, ser_last1, frame_done1;
  logic [7:0] in_data1, in_mask1, mux_data1;
  logic [2:0] mux_sel1, ser_chan1;

  assign mux_bit0 = mux_data0[mux_sel0];
  assign mux_bit1 = mux_data1[mux_sel1];

  mux_select_sequencer dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_mask(in_mask0),
    .mux_data(mux_data0), .mux_sel(mux_sel0), .mux_bit(mux_bit0),
    .ser_valid(ser_valid0), .ser_ready(ser_ready0), .ser_bit(ser_bit0), .ser_chan(ser_chan0),
    .ser_last(ser_last0), .frame_done(frame_done0)
  );

  mux_select_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_mask(in_mask1),
    .mux_data(mux_data1), .mux_sel(mux_sel1), .mux_bit(mux_bit1),
    .ser_valid(ser_valid1), .ser_ready(ser_ready1), .ser_bit(ser_bit1), .ser_chan(ser_chan1),
    .ser_last(ser_last1), .frame_done(frame_done1)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // Expected serial stream for one word: enabled channels in scan order, last flag on the final one.
  task automatic push_exp(input int which, input logic [7:0] d, input logic [7:0] m, input bit msbFirst);
    exp_t e;
    int   n, seen, ch;
    n    = $countones(m);
    seen = 0;
    for (int s = 0; s < 8; s++) begin
      ch = msbFirst ? (7 - s) : s;
      if (m[ch]) begin
        seen++;
        e.chan = 3'(ch);
        e.bitv = d[ch];
        e.last = (seen == n);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && ser_valid0 === 1'b1 && ser_ready0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected: got chan=%0d bit=%0b, required no transfer", ser_chan0, ser_bit0);
      end else begin
        e0 = q0.pop_front();
        if ({ser_chan0, ser_bit0, ser_last0} !== e0) begin
          errors++;
          $display("FAIL sb0_transfer: got chan=%0d bit=%0b last=%0b, required chan=%0d bit=%0b last=%0b",
                   ser_chan0, ser_bit0, ser_last0, e0.chan, e0.bitv, e0.last);
        end
      end
    end
    if (rst === 1'b0 && ser_valid1 === 1'b1 && ser_ready1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: got chan=%0d bit=%0b, required no transfer", ser_chan1, ser_bit1);
      end else begin
        e1 = q1.pop_front();
        if ({ser_chan1, ser_bit1, ser_last1} !== e1) begin
          errors++;
          $display("FAIL sb1_transfer: got chan=%0d bit=%0b last=%0b, required chan=%0d bit=%0b last=%0b",
                   ser_chan1, ser_bit1, ser_last1, e1.chan, e1.bitv, e1.last);
        end
      end
    end
  end

  // Waits (bounded) for in_ready, presents one word for a single cycle, returns 1ns into cycle N+1.
  task automatic send0(input logic [7:0] d, input logic [7:0] m);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready0 !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL send0_timeout: in_ready=%b, required 1 within 50 cycles", in_ready0);
    end
    in_valid0 = 1'b1;
    in_data0  = d;
    in_mask0  = m;
    push_exp(0, d, m, 1'b0);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; in_mask0 = '0; ser_ready0 = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; in_mask1 = '0; ser_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({in_ready0, ser_valid0, ser_last0, frame_done0, mux_data0, mux_sel0} !== {4'b1000, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset_dut0: got rdy=%b v=%b last=%b done=%b data=%h sel=%0d, required 1 0 0 0 00 0",
               in_ready0, ser_valid0, ser_last0, frame_done0, mux_data0, mux_sel0);
    end
    checks++;
    if ({in_ready1, ser_valid1, ser_last1, frame_done1, mux_data1, mux_sel1} !== {4'b1000, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset_dut1: got rdy=%b v=%b last=%b done=%b data=%h sel=%0d, required 1 0 0 0 00 0",
               in_ready1, ser_valid1, ser_last1, frame_done1, mux_data1, mux_sel1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ser_ready0 = 1'b1;
    send0(8'hA5, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ser_valid0 !== 1'b1 || ser_chan0 !== 3'(k)) begin
        errors++;
        $display("FAIL basic_cycle%0d: got valid=%b chan=%0d, required valid=1 chan=%0d", k, ser_valid0, ser_chan0, k);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if ({frame_done0, in_ready0, ser_valid0} !== 3'b110) begin
      errors++;
      $display("FAIL basic_done: got done=%b rdy=%b valid=%b, required 1 1 0", frame_done0, in_ready0, ser_valid0);
    end
    @(negedge clk);
    checks++;
    if (frame_done0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got done=%b one cycle later, required 0", frame_done0);
    end
  endtask

  task automatic test_sparse();
    send0(8'hF0, 8'h81);
    @(negedge clk);
    checks++;
    if ({ser_valid0, ser_chan0, ser_last0} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL sparse_first: got v=%b chan=%0d last=%b, required 1 0 0", ser_valid0, ser_chan0, ser_last0);
    end
    @(negedge clk);
    checks++;
    if ({ser_valid0, ser_chan0, ser_last0} !== {1'b1, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL sparse_second: got v=%b chan=%0d last=%b, required 1 7 1", ser_valid0, ser_chan0, ser_last0);
    end
    @(negedge clk);
    checks++;
    if ({frame_done0, ser_valid0} !== 2'b10) begin
      errors++;
      $display("FAIL sparse_done: got done=%b valid=%b, required 1 0", frame_done0, ser_valid0);
    end
  endtask

  task automatic test_empty();
    send0(8'hFF, 8'h00);
    @(negedge clk);
    checks++;
    if ({frame_done0, ser_valid0, in_ready0} !== 3'b101) begin
      errors++;
      $display("FAIL empty_done: got done=%b valid=%b rdy=%b, required 1 0 1", frame_done0, ser_valid0, in_ready0);
    end
    @(negedge clk);
    checks++;
    if ({frame_done0, ser_valid0} !== 2'b00) begin
      errors++;
      $display("FAIL empty_after: got done=%b valid=%b, required 0 0", frame_done0, ser_valid0);
    end
  endtask

  task automatic test_backpressure();
    int validCycles, doneCycle;
    bit seenDone;
    validCycles = 0; doneCycle = 0; seenDone = 1'b0;
    ser_ready0 = 1'b1;
    send0(8'h3C, 8'hFF);
    for (int c = 1; c <= 30 && !seenDone; c++) begin
      ser_ready0 = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (frame_done0 === 1'b1) begin
        seenDone  = 1'b1;
        doneCycle = c;
      end else begin
        if (ser_valid0 === 1'b1) validCycles++;
        if (c >= 3 && c <= 5) begin
          checks++;
          if ({ser_valid0, ser_chan0, ser_bit0} !== {1'b1, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL stall_cycle%0d: got v=%b chan=%0d bit=%b, required 1 2 1", c, ser_valid0, ser_chan0, ser_bit0);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    ser_ready0 = 1'b1;
    checks++;
    if (validCycles != 11 || doneCycle != 12) begin
      errors++;
      $display("FAIL stall_length: got valid cycles=%0d done cycle=%0d, required 11 and 12", validCycles, doneCycle);
    end
  endtask

  task automatic test_params_back_to_back();
    int  done1, done2, accept, firstValid2, gapZeros;
    bit  heldBad;
    done1 = 0; done2 = 0; accept = 0; firstValid2 = 0; gapZeros = 0; heldBad = 1'b0;
    ser_ready1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 8'h01; in_mask1 = 8'hFF;
    push_exp(1, 8'h01, 8'hFF, 1'b1);
    @(posedge clk);
    #1;
    in_data1 = 8'h80;
    push_exp(1, 8'h80, 8'hFF, 1'b1);
    for (int c = 1; c <= 40 && done2 == 0; c++) begin
      @(negedge clk);
      if (c <= 8 && mux_data1 !== 8'h01) heldBad = 1'b1;
      if (frame_done1 === 1'b1) begin
        if (done1 == 0) done1 = c;
        else            done2 = c;
      end
      if (done1 != 0 && accept == 0 && in_ready1 === 1'b0) gapZeros++;
      if (accept != 0 && firstValid2 == 0 && ser_valid1 === 1'b1) firstValid2 = c;
      if (accept == 0 && in_valid1 === 1'b1 && in_ready1 === 1'b1) accept = c;
      @(posedge clk);
      #1;
      if (accept != 0) in_valid1 = 1'b0;
    end
    in_valid1 = 1'b0;
    checks++;
    if (heldBad) begin
      errors++;
      $display("FAIL param_data_hold: got mux_data changed during frame 1, required 01 throughout");
    end
    checks++;
    if (done1 != 9 || gapZeros != 3) begin
      errors++;
      $display("FAIL param_gap: got done cycle=%0d in_ready-low cycles=%0d, required 9 and 3", done1, gapZeros);
    end
    checks++;
    if (accept != 12 || firstValid2 != 13 || done2 != 21) begin
      errors++;
      $display("FAIL param_second_frame: got accept=%0d first valid=%0d done=%0d, required 12 13 21",
               accept, firstValid2, done2);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit late;
    late = 1'b0;
    ser_ready0 = 1'b1;
    send0(8'hA5, 8'hFF);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ser_valid0, ser_chan0} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL rstmid_setup: got v=%b chan=%0d, required 1 4", ser_valid0, ser_chan0);
    end
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ser_valid0, mux_sel0, mux_data0, in_ready0, frame_done0} !== {1'b0, 3'd0, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_state: got v=%b sel=%0d data=%h rdy=%b done=%b, required 0 0 00 1 0",
               ser_valid0, mux_sel0, mux_data0, in_ready0, frame_done0);
    end
    repeat (4) begin
      @(negedge clk);
      if (frame_done0 !== 1'b0 || ser_valid0 !== 1'b0) late = 1'b1;
    end
    checks++;
    if (late) begin
      errors++;
      $display("FAIL rstmid_quiet: got frame_done or ser_valid after reset, required both 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_empty();
    test_backpressure();
    test_params_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, required 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
